// File: rtl/uart_responder.sv
// Board-UART stand-in for the CPU's wrn/rdn/data_ready/tbre/tsre interface.
// One-byte THR/TSR transmitter and one-byte RBR receiver, both 8N1.
module uart_responder #(
   parameter int unsigned CLK_DIV = 96
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       wrn_i,
   input  logic       rdn_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       data_oe_o,
   output logic       data_ready_o,
   output logic       tbre_o,
   output logic       tsre_o,
   output logic       txd_o,
   input  logic       rxd_i,
   output logic       overrun_o,
   output logic       frame_err_o
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

   // Registered state
   logic             wrn_q, rdn_q;
   logic [7:0]       hold, thr, tsr, rsr;
   uart_state_t      tx_state, rx_state;
   logic [CNT_W-1:0] tx_cnt, rx_cnt;
   logic [2:0]       tx_bit, rx_bit;
   logic             rx_s1, rx_s2;

   // Next-state values
   logic [7:0]       hold_n, thr_n, tsr_n, rsr_n, data_n;
   uart_state_t      tx_state_n, rx_state_n;
   logic [CNT_W-1:0] tx_cnt_n, rx_cnt_n;
   logic [2:0]       tx_bit_n, rx_bit_n;
   logic             txd_n, tsre_n, tbre_n, data_ready_n, overrun_n, frame_err_n;
   logic             tx_load, rx_commit, rx_ferr, tx_tick, rx_tick;
   logic             wr_rise, rd_rise, wr_accept;

   assign data_oe_o = ~rdn_i;
   assign wr_rise   = wrn_i & ~wrn_q;
   assign rd_rise   = rdn_i & ~rdn_q;

   // Transmit sequencer; any TSR load forces a fresh start bit.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tsr_n      = tsr;
      txd_n      = txd_o;
      tsre_n     = tsre_o;
      tx_load    = 1'b0;
      tx_tick    = (tx_cnt == BIT_LAST);
      case (tx_state)
         ST_IDLE: begin
            if (!tbre_o) tx_load = 1'b1;
         end
         ST_START: begin
            if (tx_tick) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               txd_n      = tsr[0];
               tsr_n      = {1'b0, tsr[7:1]};
               tx_state_n = ST_DATA;
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (tx_tick) begin
               tx_cnt_n = '0;
               if (tx_bit == 3'd7) begin
                  txd_n      = 1'b1;
                  tx_state_n = ST_STOP;
               end else begin
                  txd_n    = tsr[0];
                  tsr_n    = {1'b0, tsr[7:1]};
                  tx_bit_n = tx_bit + 3'd1;
               end
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (tx_tick) begin
               tx_cnt_n = '0;
               if (!tbre_o) begin
                  tx_load = 1'b1;
               end else begin
                  tsre_n     = 1'b1;
                  tx_state_n = ST_IDLE;
               end
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
         default: tx_state_n = ST_IDLE;
      endcase
      if (tx_load) begin
         tsr_n      = thr;
         txd_n      = 1'b0;
         tsre_n     = 1'b0;
         tx_cnt_n   = '0;
         tx_state_n = ST_START;
      end
   end

   // CPU write path; a write coinciding with a TSR load refills THR.
   always_comb begin
      hold_n    = wrn_i ? hold : data_i;
      thr_n     = thr;
      tbre_n    = tbre_o;
      wr_accept = wr_rise & (tbre_o | tx_load);
      if (tx_load) tbre_n = 1'b1;
      if (wr_accept) begin
         thr_n  = hold;
         tbre_n = 1'b0;
      end
   end

   // Receive sequencer with mid-bit start validation.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rsr_n      = rsr;
      rx_commit  = 1'b0;
      rx_ferr    = 1'b0;
      rx_tick    = (rx_cnt == BIT_LAST);
      case (rx_state)
         ST_IDLE: begin
            rx_cnt_n = '0;
            if (!rx_s2) rx_state_n = ST_START;
         end
         ST_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (rx_tick) begin
               rx_cnt_n = '0;
               rsr_n    = {rx_s2, rsr[7:1]};
               if (rx_bit == 3'd7) rx_state_n = ST_STOP;
               else                rx_bit_n   = rx_bit + 3'd1;
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (rx_tick) begin
               rx_cnt_n   = '0;
               rx_state_n = ST_IDLE;
               rx_commit  = rx_s2;
               rx_ferr    = ~rx_s2;
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
         default: rx_state_n = ST_IDLE;
      endcase
   end

   // CPU read path; an RX commit outranks a read on the same edge.
   always_comb begin
      data_n       = rx_commit ? rsr : data_o;
      data_ready_n = data_ready_o;
      if (rd_rise)   data_ready_n = 1'b0;
      if (rx_commit) data_ready_n = 1'b1;
      overrun_n    = rx_commit & data_ready_o & ~rd_rise;
      frame_err_n  = rx_ferr;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wrn_q        <= 1'b1;
         rdn_q        <= 1'b1;
         hold         <= '0;
         thr          <= '0;
         tsr          <= '0;
         rsr          <= '0;
         tx_state     <= ST_IDLE;
         rx_state     <= ST_IDLE;
         tx_cnt       <= '0;
         rx_cnt       <= '0;
         tx_bit       <= '0;
         rx_bit       <= '0;
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         data_o       <= '0;
         data_ready_o <= 1'b0;
         tbre_o       <= 1'b1;
         tsre_o       <= 1'b1;
         txd_o        <= 1'b1;
         overrun_o    <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         wrn_q        <= wrn_i;
         rdn_q        <= rdn_i;
         hold         <= hold_n;
         thr          <= thr_n;
         tsr          <= tsr_n;
         rsr          <= rsr_n;
         tx_state     <= tx_state_n;
         rx_state     <= rx_state_n;
         tx_cnt       <= tx_cnt_n;
         rx_cnt       <= rx_cnt_n;
         tx_bit       <= tx_bit_n;
         rx_bit       <= rx_bit_n;
         rx_s1        <= rxd_i;
         rx_s2        <= rx_s1;
         data_o       <= data_n;
         data_ready_o <= data_ready_n;
         tbre_o       <= tbre_n;
         tsre_o       <= tsre_n;
         txd_o        <= txd_n;
         overrun_o    <= overrun_n;
         frame_err_o  <= frame_err_n;
      end
   end

endmodule

// File: tb/tb_uart_responder.sv
// Directed self-checking bench for uart_responder at CLK_DIV=4.
module tb_uart_responder;

   localparam int unsigned CLK_DIV = 4;

   logic       CLK = 1'b0;
   logic       RST, wrn_i, rdn_i, rxd_i;
   logic [7:0] data_i;
   logic [7:0] data_o;
   logic       data_oe_o, data_ready_o, tbre_o, tsre_o, txd_o, overrun_o, frame_err_o;

   int n_tests = 0;
   int n_fail  = 0;
   int ov_seen = 0;
   int fe_seen = 0;

   uart_responder #(.CLK_DIV(CLK_DIV)) dut (
      .CLK(CLK), .RST(RST), .wrn_i(wrn_i), .rdn_i(rdn_i), .data_i(data_i),
      .data_o(data_o), .data_oe_o(data_oe_o), .data_ready_o(data_ready_o),
      .tbre_o(tbre_o), .tsre_o(tsre_o), .txd_o(txd_o), .rxd_i(rxd_i),
      .overrun_o(overrun_o), .frame_err_o(frame_err_o)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rx_tick();
      tick();
      if (overrun_o === 1'b1)   ov_seen++;
      if (frame_err_o === 1'b1) fe_seen++;
   endtask

   task automatic rx_idle(input int n);
      for (int i = 0; i < n; i++) rx_tick();
   endtask

   // Expected line level for bit slot b of an 8N1 frame carrying d.
   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return d[b-1];
   endfunction

   task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
      for (int b = 0; b < 10; b++) begin
         rxd_i = (b == 9) ? stop_bit : frame_bit(d, b);
         for (int j = 0; j < int'(CLK_DIV); j++) rx_tick();
      end
      rxd_i = 1'b1;
   endtask

   task automatic cpu_read();
      rdn_i = 1'b0;
      tick();
      rdn_i = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      RST = 1'b1; wrn_i = 1'b1; rdn_i = 1'b1; rxd_i = 1'b1; data_i = 8'h00;
      repeat (3) tick();
      RST = 1'b0;
      tick();
      n_tests++; if (tbre_o !== 1'b1) begin n_fail++; $display("FAIL reset_tbre got %b want 1", tbre_o); end
      n_tests++; if (tsre_o !== 1'b1) begin n_fail++; $display("FAIL reset_tsre got %b want 1", tsre_o); end
      n_tests++; if (txd_o !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd_o); end
      n_tests++; if (data_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready got %b want 0", data_ready_o); end
      n_tests++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_o); end
      n_tests++; if (overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got ov=%b fe=%b want 0 0", overrun_o, frame_err_o); end
   endtask

   task automatic test_write_a5();
      int bad = 0;
      int first = -1;
      data_i = 8'hA5; wrn_i = 1'b0;
      repeat (2) tick();
      wrn_i = 1'b1;
      tick();
      n_tests++; if (tbre_o !== 1'b0 || txd_o !== 1'b1) begin n_fail++; $display("FAIL wr_thr_load got tbre=%b txd=%b want 0 1", tbre_o, txd_o); end
      tick();
      n_tests++; if (tbre_o !== 1'b1 || txd_o !== 1'b0 || tsre_o !== 1'b0) begin n_fail++; $display("FAIL wr_tsr_load got tbre=%b txd=%b tsre=%b want 1 0 0", tbre_o, txd_o, tsre_o); end
      for (int c = 0; c < 40; c++) begin
         if (txd_o !== frame_bit(8'hA5, c / int'(CLK_DIV))) begin
            bad++;
            if (first < 0) first = c;
         end
         if (c == 39 && tsre_o !== 1'b0) bad++;
         tick();
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL tx_a5_stream got %0d bad cycles (first at %0d) want 0", bad, first); end
      n_tests++; if (tsre_o !== 1'b1 || txd_o !== 1'b1) begin n_fail++; $display("FAIL tx_a5_done got tsre=%b txd=%b want 1 1", tsre_o, txd_o); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      int first = -1;
      repeat (3) tick();
      data_i = 8'h11; wrn_i = 1'b0;
      tick();
      wrn_i = 1'b1;
      tick();
      tick();
      for (int c = 0; c < 80; c++) begin
         logic [7:0] d;
         d = (c < 40) ? 8'h11 : 8'h22;
         if (txd_o !== frame_bit(d, (c % 40) / int'(CLK_DIV))) begin
            bad++;
            if (first < 0) first = c;
         end
         case (c)
            0: begin data_i = 8'h22; wrn_i = 1'b0; end
            1: wrn_i = 1'b1;
            2: begin
               n_tests++; if (tbre_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got tbre=%b want 0", tbre_o); end
               data_i = 8'h33; wrn_i = 1'b0;
            end
            3: wrn_i = 1'b1;
            4: begin
               n_tests++; if (tbre_o !== 1'b0) begin n_fail++; $display("FAIL b2b_third_drop got tbre=%b want 0", tbre_o); end
            end
            40: begin
               n_tests++; if (tbre_o !== 1'b1 || tsre_o !== 1'b0) begin n_fail++; $display("FAIL b2b_reload got tbre=%b tsre=%b want 1 0", tbre_o, tsre_o); end
            end
            default: ;
         endcase
         tick();
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_stream got %0d bad cycles (first at %0d) want 0", bad, first); end
      repeat (4) tick();
      n_tests++; if (tsre_o !== 1'b1 || txd_o !== 1'b1 || tbre_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got tsre=%b txd=%b tbre=%b want 1 1 1", tsre_o, txd_o, tbre_o); end
   endtask

   task automatic test_rx_read();
      ov_seen = 0; fe_seen = 0;
      rx_frame(8'h3C, 1'b1);
      n_tests++; if (data_ready_o !== 1'b0) begin n_fail++; $display("FAIL rx_early got data_ready=%b want 0", data_ready_o); end
      rx_tick();
      n_tests++; if (data_ready_o !== 1'b1 || data_o !== 8'h3C) begin n_fail++; $display("FAIL rx_3c got ready=%b data=%h want 1 3c", data_ready_o, data_o); end
      rdn_i = 1'b0;
      tick();
      n_tests++; if (data_oe_o !== 1'b1) begin n_fail++; $display("FAIL read_oe got %b want 1", data_oe_o); end
      tick();
      n_tests++; if (data_o !== 8'h3C || data_ready_o !== 1'b1) begin n_fail++; $display("FAIL read_hold got data=%h ready=%b want 3c 1", data_o, data_ready_o); end
      rdn_i = 1'b1;
      tick();
      n_tests++; if (data_ready_o !== 1'b0 || data_oe_o !== 1'b0) begin n_fail++; $display("FAIL read_clear got ready=%b oe=%b want 0 0", data_ready_o, data_oe_o); end
   endtask

   task automatic test_rx_overrun();
      ov_seen = 0; fe_seen = 0;
      rx_frame(8'h01, 1'b1);
      rx_frame(8'h02, 1'b1);
      rx_idle(2);
      n_tests++; if (ov_seen != 1) begin n_fail++; $display("FAIL overrun_count got %0d want 1", ov_seen); end
      n_tests++; if (data_o !== 8'h02 || data_ready_o !== 1'b1) begin n_fail++; $display("FAIL overrun_data got data=%h ready=%b want 02 1", data_o, data_ready_o); end
      cpu_read();
   endtask

   task automatic test_rx_frame_err();
      ov_seen = 0; fe_seen = 0;
      rx_frame(8'h55, 1'b0);
      rx_idle(10);
      n_tests++; if (fe_seen != 1) begin n_fail++; $display("FAIL frame_err_count got %0d want 1", fe_seen); end
      n_tests++; if (data_ready_o !== 1'b0 || data_o !== 8'h02) begin n_fail++; $display("FAIL frame_err_rbr got ready=%b data=%h want 0 02", data_ready_o, data_o); end
   endtask

   task automatic test_rx_glitch();
      ov_seen = 0; fe_seen = 0;
      rxd_i = 1'b0;
      rx_tick();
      rxd_i = 1'b1;
      rx_idle(60);
      n_tests++; if (data_ready_o !== 1'b0 || data_o !== 8'h02 || fe_seen != 0) begin n_fail++; $display("FAIL glitch got ready=%b data=%h fe=%0d want 0 02 0", data_ready_o, data_o, fe_seen); end
   endtask

   task automatic test_reset_midframe();
      data_i = 8'h0F; wrn_i = 1'b0;
      tick();
      wrn_i = 1'b1;
      repeat (12) tick();
      n_tests++; if (tsre_o !== 1'b0) begin n_fail++; $display("FAIL midframe_busy got tsre=%b want 0", tsre_o); end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_tests++; if (txd_o !== 1'b1 || tsre_o !== 1'b1 || tbre_o !== 1'b1) begin n_fail++; $display("FAIL midframe_abort got txd=%b tsre=%b tbre=%b want 1 1 1", txd_o, tsre_o, tbre_o); end
      repeat (50) begin
         tick();
         if (txd_o !== 1'b1) break;
      end
      n_tests++; if (txd_o !== 1'b1 || tsre_o !== 1'b1) begin n_fail++; $display("FAIL midframe_quiet got txd=%b tsre=%b want 1 1", txd_o, tsre_o); end
   endtask

   initial begin
      test_reset();
      test_write_a5();
      test_back_to_back();
      test_rx_read();
      test_rx_overrun();
      test_rx_frame_err();
      test_rx_glitch();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_responder.md
Name: uart_responder

Overview:
- Synthesizable model of the board UART device at the far end of the CPU's wrn/rdn/data_ready/tbre/tsre interface.
- Accepts byte writes and byte reads from the CPU memory stage, serializes TX and deserializes RX as 8N1.
- Sits between the CPU's UART-mapped access logic and the FPGA serial pins, so the CPU can be exercised without the external UART chip.

Parameters:
- CLK_DIV, 96, CLK cycles per bit period (11.0592 MHz / 115200). Legal range 4..65535.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- wrn_i  input  1  write strobe from CPU, active low.
- rdn_i  input  1  read strobe from CPU, active low.
- data_i  input  8  write data from CPU bus (Ram1Data[7:0]).
- data_o  output  8  received byte (RBR) presented to CPU bus.
- data_oe_o  output  1  bus drive enable for data_o; combinational, equals ~rdn_i.
- data_ready_o  output  1  RBR holds an unread byte.
- tbre_o  output  1  transmit holding register (THR) empty.
- tsre_o  output  1  transmit shift register idle.
- txd_o  output  1  serial transmit line; idle high.
- rxd_i  input  1  serial receive line, asynchronous.
- overrun_o  output  1  one-cycle pulse: a received byte overwrote an unread RBR.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: data_o=0, data_ready_o=0, tbre_o=1, tsre_o=1, txd_o=1, overrun_o=0, frame_err_o=0. TX and RX FSMs go to IDLE; baud counters clear. RST mid-frame aborts the frame immediately; txd_o returns high on the next edge.
- Strobe edges: wrn_i and rdn_i are registered once. A rising edge is prev=0, now=1.
- Write:
  - While wrn_i=0, data_i is captured every cycle into a hold register.
  - On the wrn_i rising edge with tbre_o=1: hold is copied to THR and tbre_o<=0.
  - With tbre_o=0 the write is dropped; no state changes.
- TX FSM states: IDLE, START, DATA, STOP. Each state lasts CLK_DIV cycles per bit.
  - IDLE: when THR is full, load TSR from THR. In the same edge set tbre_o<=1, tsre_o<=0, txd_o<=0, and enter START.
  - START -> DATA: shift out 8 bits, LSB first.
  - DATA -> STOP: txd_o=1.
  - End of STOP: if THR is full, reload and begin START with no idle gap. Otherwise set tsre_o<=1 and return to IDLE.
  - Latency from the wrn_i rising edge to the txd_o falling edge is 2 cycles; the registered strobe accounts for 1 of them.
- RX: rxd_i passes through a 2-flop synchronizer. FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized low.
  - START: after CLK_DIV/2 cycles, resample. If high, treat as a glitch and return to IDLE. If low, enter DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits LSB first.
  - STOP: sample after CLK_DIV cycles.
    - If high: write RBR (data_o), set data_ready_o<=1, and pulse overrun_o if data_ready_o was already 1.
    - If low: discard the byte, pulse frame_err_o, and leave RBR unchanged.
    - In both cases return to IDLE.
- Read:
  - data_o is stable while rdn_i=0.
  - On the rdn_i rising edge, data_ready_o<=0.
  - If an RX commit happens on the same edge, the commit wins: RBR updates, data_ready_o stays 1, and there is no overrun pulse.
- Simultaneous write and TX load on the same edge: THR load from hold takes priority. tbre_o ends at 0 and the old THR content is already in TSR.
- Baud counters are 16-bit and count 0..CLK_DIV-1, then wrap to 0.

Test Plan (CLK_DIV=4):
- Reset: hold RST=1 for 3 cycles, then release. Required: tbre_o=1, tsre_o=1, txd_o=1, data_ready_o=0, data_o=0.
- Write 0xA5 (wrn_i low for 2 cycles, then high). Required:
  - tbre_o low 1 cycle after the rising edge, then high again when TSR loads.
  - txd_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - tsre_o returns to 1 after 40 cycles.
- Back-to-back writes of 0x11 then 0x22: second write issued while the first is shifting, third write issued while tbre_o=0. Required: two contiguous frames with no idle gap; the third byte is dropped.
- Drive rxd_i with frame 0x3C. Required: data_ready_o=1 and data_o=0x3C after the stop sample. Then pulse rdn_i; required: data_ready_o=0 one cycle after the rising edge.
- Two RX frames 0x01 then 0x02 with no read between them. Required: overrun_o pulses once and data_o=0x02.
- RX frame 0x55 with stop bit low. Required: frame_err_o pulses, data_ready_o stays 0. Then a 1-cycle low glitch on rxd_i; required: no byte received.
